control_sequencer: RTL and testbench

Hardwired control unit that drives the CPU datapath's control inputs. It decodes the instruction register and steps through the fetch (T0–T2) and execute (T3–T7) micro-steps, one step per clock, asserting the register-select, bus-drive, register-load, memory and ALU-operation signals each step needs. It sits directly upstream of the datapath and replaces hand-driven testbench stimulus with autonomous instruction sequencing.

---
 rtl/control_sequencer.sv | 154 +++++++++++++++
 tb/tb_control_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch (T0-T2) and execute (T3-T7) micro-steps,
// decoding IR[31:27] into the datapath's select, bus-drive, load and ALU strobes.
module control_sequencer #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic [4:0]  opcode,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout,
  output logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Outportin, CONin,
  output logic        IncPC, Read, Write
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NONE
  } iclass_t;

  state_t      state, next_state;
  iclass_t     iclass;
  logic [4:0]  op;
  logic        unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_comb begin
    case (op) inside
      5'd0:            iclass = C_LD;
      5'd1:            iclass = C_LDI;
      5'd2:            iclass = C_ST;
      [5'd3:5'd11]:    iclass = C_ALU;
      [5'd12:5'd14]:   iclass = C_IMM;
      5'd15, 5'd16:    iclass = C_MULDIV;
      5'd17, 5'd18:    iclass = C_NEGNOT;
      5'd19:           iclass = C_BR;
      5'd20:           iclass = C_JR;
      5'd22:           iclass = C_IN;
      5'd23:           iclass = C_OUT;
      5'd24:           iclass = C_MFHI;
      5'd25:           iclass = C_MFLO;
      5'd27:           iclass = C_HALT;
      default:         iclass = C_NONE;   // nop, jal, undefined
    endcase
  end

  // NOTE: state register uses non-blocking assignment so every flop samples
  // pre-edge values; combinational blocks below use blocking assignment.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state <= S_RST;
    else        state <= next_state;
  end

  // NOTE: every output and next_state gets a default first so no path through
  // the case statements can infer a latch.
  always_comb begin
    next_state = S_T0;
    Run = (state != S_HALT);
    opcode = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Outportin, CONin} = '0;
    {IncPC, Read, Write} = '0;

    case (state)
      S_RST: next_state = S_T0;
      S_T0: begin
        {PCout, MARin, IncPC, Zin} = '1;
        next_state = S_T1;
      end
      S_T1: begin
        {Zlowout, PCin, Read, MDRin} = '1;
        next_state = S_T2;
      end
      S_T2: begin
        {MDRout, IRin} = '1;
        if (Stop)                 next_state = S_HALT;
        else if (iclass == C_NONE) next_state = S_T0;
        else                      next_state = S_T3;
      end
      S_T3: begin
        next_state = S_T4;
        case (iclass)
          C_ALU, C_IMM:        {Grb, Rout, Yin} = '1;
          C_LDI, C_LD, C_ST:   {Grb, BAout, Yin} = '1;
          C_MULDIV:            {Gra, Rout, Yin} = '1;
          C_NEGNOT: begin
            {Grb, Rout, Zin} = '1;
            opcode = op;
          end
          C_BR:                {Gra, Rout, CONin} = '1;
          C_JR:   begin {Gra, Rout, PCin} = '1;        next_state = S_T0; end
          C_IN:   begin {Inportout, Gra, Rin} = '1;    next_state = S_T0; end
          C_OUT:  begin {Gra, Rout, Outportin} = '1;   next_state = S_T0; end
          C_MFHI: begin {HIout, Gra, Rin} = '1;        next_state = S_T0; end
          C_MFLO: begin {LOout, Gra, Rin} = '1;        next_state = S_T0; end
          C_HALT:              next_state = S_HALT;
          default:             next_state = S_T0;
        endcase
      end
      S_T4: begin
        next_state = S_T5;
        case (iclass)
          C_ALU:    begin {Grc, Rout, Zin} = '1; opcode = op; end
          C_IMM:    begin {Cout, Zin} = '1;      opcode = op; end
          C_LDI, C_LD, C_ST: begin {Cout, Zin} = '1; opcode = ADD_OP; end
          C_MULDIV: begin {Grb, Rout, Zin} = '1; opcode = op; end
          C_NEGNOT: begin {Zlowout, Gra, Rin} = '1; next_state = S_T0; end
          C_BR:     {PCout, Yin} = '1;
          default:  next_state = S_T0;
        endcase
      end
      S_T5: begin
        next_state = S_T6;
        case (iclass)
          C_ALU, C_IMM, C_LDI: begin {Zlowout, Gra, Rin} = '1; next_state = S_T0; end
          C_LD, C_ST:  {Zlowout, MARin} = '1;
          C_MULDIV:    {Zlowout, LOin} = '1;
          C_BR:        begin {Cout, Zin} = '1; opcode = ADD_OP; end
          default:     next_state = S_T0;
        endcase
      end
      S_T6: begin
        next_state = S_T0;
        case (iclass)
          C_LD:     begin {Read, MDRin} = '1;      next_state = S_T7; end
          C_ST:     begin {Gra, Rout, MDRin} = '1; next_state = S_T7; end
          C_MULDIV: {Zhighout, HIin} = '1;
          C_BR:     if (CON_FF) {Zlowout, PCin} = '1;
          default:  ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD:    {MDRout, Gra, Rin} = '1;
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction expected strobe
// sequences built from the instruction-set rules, compared every cycle.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        CON_FF, Stop;
  logic        Run;
  logic [4:0]  opcode;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Outportin, CONin;
  logic        IncPC, Read, Write;

  control_sequencer #(.ADD_OP(5'b00011)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .Run(Run), .opcode(opcode),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .Inportout(Inportout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .Outportin(Outportin), .CONin(CONin),
    .IncPC(IncPC), .Read(Read), .Write(Write)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        run;
    logic [4:0]  opc;
    logic [26:0] ctrl;
  } step_t;

  localparam logic [26:0] GRA = 27'd1 << 0,  GRB = 27'd1 << 1,  GRC = 27'd1 << 2;
  localparam logic [26:0] RIN = 27'd1 << 3,  ROUT = 27'd1 << 4, BAOUT = 27'd1 << 5;
  localparam logic [26:0] PCOUT = 27'd1 << 6, MDROUT = 27'd1 << 7, ZHIOUT = 27'd1 << 8;
  localparam logic [26:0] ZLOOUT = 27'd1 << 9, HIOUT = 27'd1 << 10, LOOUT = 27'd1 << 11;
  localparam logic [26:0] INPOUT = 27'd1 << 12, COUT = 27'd1 << 13, PCIN = 27'd1 << 14;
  localparam logic [26:0] IRIN = 27'd1 << 15, MARIN = 27'd1 << 16, MDRIN = 27'd1 << 17;
  localparam logic [26:0] YIN = 27'd1 << 18, ZIN = 27'd1 << 19, HIIN = 27'd1 << 20;
  localparam logic [26:0] LOIN = 27'd1 << 21, OUTPIN = 27'd1 << 22, CONIN = 27'd1 << 23;
  localparam logic [26:0] INCPC = 27'd1 << 24, READ = 27'd1 << 25, WRITE = 27'd1 << 26;
  localparam logic [4:0]  ADD = 5'b00011;

  logic [26:0] ctrl_vec;
  step_t       obs;
  assign ctrl_vec = {Write, Read, IncPC, CONin, Outportin, LOin, HIin, Zin, Yin, MDRin,
                     MARin, IRin, PCin, Cout, Inportout, LOout, HIout, Zlowout, Zhighout,
                     MDRout, PCout, BAout, Rout, Rin, Grc, Grb, Gra};
  assign obs = {Run, opcode, ctrl_vec};

  int    n_tests = 0;
  int    n_fail  = 0;
  step_t exp_q[$];
  step_t t0_word;

  function automatic void push(input logic [26:0] c, input logic [4:0] o = 5'd0);
    exp_q.push_back({1'b1, o, c});
  endfunction

  // Expected per-cycle strobes of a whole instruction, from T0 to its last step.
  function automatic void build_seq(input logic [4:0] op, input logic con);
    int n;
    n = int'(op);
    exp_q.delete();
    push(PCOUT | MARIN | INCPC | ZIN);
    push(ZLOOUT | PCIN | READ | MDRIN);
    push(MDROUT | IRIN);
    if (n >= 3 && n <= 11) begin
      push(GRB | ROUT | YIN); push(GRC | ROUT | ZIN, op); push(ZLOOUT | GRA | RIN);
    end else if (n >= 12 && n <= 14) begin
      push(GRB | ROUT | YIN); push(COUT | ZIN, op); push(ZLOOUT | GRA | RIN);
    end else if (n <= 2) begin
      push(GRB | BAOUT | YIN); push(COUT | ZIN, ADD);
      if (n == 1) push(ZLOOUT | GRA | RIN);
      else begin
        push(ZLOOUT | MARIN);
        if (n == 0) begin push(READ | MDRIN); push(MDROUT | GRA | RIN); end
        else begin push(GRA | ROUT | MDRIN); push(WRITE); end
      end
    end else if (n == 15 || n == 16) begin
      push(GRA | ROUT | YIN); push(GRB | ROUT | ZIN, op); push(ZLOOUT | LOIN); push(ZHIOUT | HIIN);
    end else if (n == 17 || n == 18) begin
      push(GRB | ROUT | ZIN, op); push(ZLOOUT | GRA | RIN);
    end else if (n == 19) begin
      push(GRA | ROUT | CONIN); push(PCOUT | YIN); push(COUT | ZIN, ADD);
      push(con ? (ZLOOUT | PCIN) : 27'd0);
    end else if (n == 20) push(GRA | ROUT | PCIN);
    else if (n == 22) push(INPOUT | GRA | RIN);
    else if (n == 23) push(GRA | ROUT | OUTPIN);
    else if (n == 24) push(HIOUT | GRA | RIN);
    else if (n == 25) push(LOOUT | GRA | RIN);
  endfunction

  // Pulse clear and leave the DUT at a negedge inside T0.
  task automatic do_reset();
    clear = 1'b0; Stop = 1'b0;
    @(negedge Clock);
    clear = 1'b1;
    @(posedge Clock); @(negedge Clock);
  endtask

  // Runs one instruction from T0, checking every step and the return to T0.
  task automatic exec_instr(input logic [31:0] ir, input logic con, input string name);
    IR = ir; CON_FF = con;
    build_seq(ir[31:27], con);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s step T%0d: got %h expected %h", name, i, obs, exp_q[i]);
      end
      Stop = (i >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge Clock); @(negedge Clock);
    end
    Stop = 1'b0;
    n_tests++;
    if (obs !== t0_word) begin
      n_fail++;
      $display("FAIL %s latency %0d: got %h expected T0 %h", name, exp_q.size(), obs, t0_word);
    end
  endtask

  task automatic test_reset();
    IR = 32'h19A28000; CON_FF = 1'b0; Stop = 1'b0;
    clear = 1'b0;
    #1;
    n_tests++;
    if (obs !== {1'b1, 5'd0, 27'd0}) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, {1'b1, 5'd0, 27'd0});
    end
    @(negedge Clock); clear = 1'b1;
    @(posedge Clock); @(negedge Clock);
    n_tests++;
    if (obs !== t0_word) begin
      n_fail++; $display("FAIL reset_to_t0: got %h expected %h", obs, t0_word);
    end
    // walk an add into T4, then clear mid-step
    build_seq(5'b00011, 1'b0);
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    n_tests++;
    if (obs !== exp_q[4]) begin
      n_fail++; $display("FAIL reset_pre_t4: got %h expected %h", obs, exp_q[4]);
    end
    #2 clear = 1'b0;
    #1;
    n_tests++;
    if (obs !== {1'b1, 5'd0, 27'd0}) begin
      n_fail++; $display("FAIL reset_async_mid_t4: got %h expected %h", obs, {1'b1, 5'd0, 27'd0});
    end
    @(posedge Clock); @(negedge Clock);
    n_tests++;
    if (obs !== {1'b1, 5'd0, 27'd0}) begin
      n_fail++; $display("FAIL reset_held: got %h expected %h", obs, {1'b1, 5'd0, 27'd0});
    end
    clear = 1'b1;
    @(posedge Clock); @(negedge Clock);
    n_tests++;
    if (obs !== t0_word) begin
      n_fail++; $display("FAIL reset_release_t0: got %h expected %h", obs, t0_word);
    end
  endtask

  task automatic test_directed();
    exec_instr(32'h19A28000, 1'b0, "add_r3_r4_r5");
    exec_instr({5'b00000, 27'h0123456}, 1'b0, "ld");
    exec_instr({5'b00010, 27'h0654321}, 1'b1, "st");
    exec_instr({5'b10011, 27'h0800004}, 1'b1, "branch_taken");
    exec_instr({5'b10011, 27'h0800004}, 1'b0, "branch_not_taken");
    exec_instr({5'b01111, 27'h1200000}, 1'b0, "mul");
    exec_instr({5'b10001, 27'h0000000}, 1'b0, "neg");
    exec_instr({5'b11010, 27'h7FFFFFF}, 1'b0, "nop");
    exec_instr({5'b11111, 27'h0000000}, 1'b0, "undefined");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int k = 0; k < 60; k++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'b11011);
      exec_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", k, op));
    end
  endtask

  task automatic test_halt();
    build_seq(5'b11010, 1'b0);
    IR = {5'b11011, 27'h0};
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (obs !== exp_q[i]) begin
        n_fail++; $display("FAIL halt_fetch T%0d: got %h expected %h", i, obs, exp_q[i]);
      end
      @(posedge Clock); @(negedge Clock);
    end
    n_tests++;
    if ({opcode, ctrl_vec} !== 32'd0) begin
      n_fail++; $display("FAIL halt_t3_strobes: got %h expected 0", {opcode, ctrl_vec});
    end
    for (int i = 0; i < 10; i++) begin
      Stop = 1'($urandom_range(0, 1));
      @(posedge Clock); @(negedge Clock);
      n_tests++;
      if (obs !== {1'b0, 5'd0, 27'd0}) begin
        n_fail++; $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs, {1'b0, 5'd0, 27'd0});
      end
    end
    do_reset();
  endtask

  task automatic test_stop();
    IR = 32'h19A28000;
    @(posedge Clock); @(negedge Clock);
    @(posedge Clock); @(negedge Clock);
    Stop = 1'b1;
    @(posedge Clock); @(negedge Clock);
    Stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs !== {1'b0, 5'd0, 27'd0}) begin
        n_fail++; $display("FAIL stop_halt cycle %0d: got %h expected %h", i, obs, {1'b0, 5'd0, 27'd0});
      end
      @(posedge Clock); @(negedge Clock);
    end
    do_reset();
    n_tests++;
    if (obs !== t0_word) begin
      n_fail++; $display("FAIL stop_recover_t0: got %h expected %h", obs, t0_word);
    end
  endtask

  initial begin
    t0_word = {1'b1, 5'd0, PCOUT | MARIN | INCPC | ZIN};
    test_reset();
    test_directed();
    test_random();
    test_halt();
    test_stop();
    exec_instr(32'h19A28000, 1'b0, "add_after_stop");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  always @(negedge Clock) begin
    if (clear === 1'b1 && Read === 1'b1 && Write === 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL read_write_exclusive: Read=%b Write=%b", Read, Write);
    end
    if (clear === 1'b1 && Rin === 1'b1 && Rout === 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL rin_rout_exclusive: Rin=%b Rout=%b", Rin, Rout);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
